jtag_dr_receiver: RTL and testbench

Upstream counterpart of the JTAG TDO word transmitter: captures serial TDI bits during Shift-DR into a WIDTH-bit word, MSB first, matching the transmitter's bit order. On Update-DR it validates the frame length and presents the word to the command/register logic over a valid/ready handshake. It sits between the TAP controller (shift_en/update strobes) and the data-register consumers.

---
 rtl/jtag_pkg.sv | 18 +
 rtl/jtag_dr_receiver.sv | 125 ++++++++++++
 tb/tb_jtag_dr_receiver.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions used by the DR receiver and the TDO word transmitter.
package jtag_pkg;

  // Data register word width shared by both directions of the link.
  localparam int JTAG_WORD_WIDTH = 32;

  // Receiver frame state: waiting for the first shifted bit, or inside a frame.
  typedef enum logic [0:0] {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_t;

  // Bits needed for a counter that must hold every value from 0 up to width.
  function automatic int countWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/jtag_dr_receiver.sv
// JTAG data register receiver: collects TDI bits MSB first during Shift-DR,
// checks the frame length on Update-DR and hands the word to the consumer
// over a valid/ready handshake.
module jtag_dr_receiver
  import jtag_pkg::*;
#(
  parameter int WIDTH = JTAG_WORD_WIDTH
) (
  input  logic             clk_tck,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             update,
  input  logic             tdi,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             overflow,
  output logic             short_frame,
  output logic             dropped
);

  localparam int CW = countWidth(WIDTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(WIDTH);

  rx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [CW-1:0]    bitCnt_q, bitCnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] dataOut_q, dataOut_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             shortFrame_q, shortFrame_d;
  logic             dropped_q, dropped_d;
  logic             loadWord;

  // Frame tracking, length check on close, and output slot handshake.
  always_comb begin
    state_d      = state_q;
    shiftReg_d   = shiftReg_q;
    bitCnt_d     = bitCnt_q;
    ovf_d        = ovf_q;
    dataOut_d    = dataOut_q;
    overflow_d   = overflow_q;
    shortFrame_d = 1'b0;
    dropped_d    = 1'b0;
    loadWord     = 1'b0;

    case (state_q)
      RX_IDLE: begin
        // update without any shifted bits is ignored; update also wins over shift_en.
        if (shift_en && !update) begin
          state_d    = RX_SHIFT;
          shiftReg_d = {shiftReg_q[WIDTH-2:0], tdi};
          bitCnt_d   = CW'(1);
          ovf_d      = 1'b0;
        end
      end
      RX_SHIFT: begin
        if (update) begin
          state_d  = RX_IDLE;
          bitCnt_d = '0;
          ovf_d    = 1'b0;
          if (bitCnt_q != FULL_COUNT) begin
            shortFrame_d = 1'b1;
          end else if (!valid_q || ready) begin
            loadWord   = 1'b1;
            dataOut_d  = shiftReg_q;
            overflow_d = ovf_q;
          end else begin
            dropped_d = 1'b1;
          end
        end else if (shift_en) begin
          shiftReg_d = {shiftReg_q[WIDTH-2:0], tdi};
          if (bitCnt_q == FULL_COUNT) begin
            ovf_d = 1'b1;
          end else begin
            bitCnt_d = bitCnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase

    valid_d = valid_q;
    if (loadWord) begin
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_tck) begin
    if (reset) begin
      state_q      <= RX_IDLE;
      shiftReg_q   <= '0;
      bitCnt_q     <= '0;
      ovf_q        <= 1'b0;
      dataOut_q    <= '0;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
      shortFrame_q <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shiftReg_q   <= shiftReg_d;
      bitCnt_q     <= bitCnt_d;
      ovf_q        <= ovf_d;
      dataOut_q    <= dataOut_d;
      valid_q      <= valid_d;
      overflow_q   <= overflow_d;
      shortFrame_q <= shortFrame_d;
      dropped_q    <= dropped_d;
    end
  end

  assign data_out    = dataOut_q;
  assign valid       = valid_q;
  assign overflow    = overflow_q;
  assign short_frame = shortFrame_q;
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_jtag_dr_receiver.sv
// Self-checking bench for jtag_dr_receiver: directed scenarios plus random
// frames, compared every cycle against a bit-queue frame model.
module tb_jtag_dr_receiver;

  localparam int W = 32;

  logic          clk_tck = 1'b0;
  logic          reset;
  logic          shift_en;
  logic          update;
  logic          tdi;
  logic [W-1:0]  data_out;
  logic          valid;
  logic          ready;
  logic          overflow;
  logic          short_frame;
  logic          dropped;

  int checkCount = 0;
  int failCount  = 0;

  // Model state: bits of the open frame, and the delivered-word slot.
  bit           mInFrame;
  bit           mBits[$];
  bit           mLastBits[$];
  bit           mValid;
  logic [W-1:0] mData;
  bit           mOvf;
  bit           mShort;
  bit           mDrop;

  jtag_dr_receiver #(.WIDTH(W)) dut (
    .clk_tck    (clk_tck),
    .reset      (reset),
    .shift_en   (shift_en),
    .update     (update),
    .tdi        (tdi),
    .data_out   (data_out),
    .valid      (valid),
    .ready      (ready),
    .overflow   (overflow),
    .short_frame(short_frame),
    .dropped    (dropped)
  );

  always #5 clk_tck = ~clk_tck;

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Frame model: a frame is a list of bits; a good frame has exactly 32 or
  // more, and the delivered word is its last 32 bits in arrival order.
  task automatic modelEdge(input bit rst, input bit sh, input bit up, input bit bitIn,
                           input bit rdy);
    bit           load;
    logic [W-1:0] word;
    int           len;
    load   = 0;
    word   = '0;
    mShort = 0;
    mDrop  = 0;
    if (rst) begin
      mInFrame = 0;
      mBits.delete();
      mValid = 0;
      mData  = '0;
      mOvf   = 0;
      return;
    end
    if (up && mInFrame) begin
      len = mBits.size();
      if (len < W) begin
        mShort = 1;
      end else begin
        for (int i = len - W; i < len; i++) word = {word[W-2:0], mBits[i]};
        if (!mValid || rdy) begin
          load = 1;
          mLastBits.delete();
          for (int i = len - W; i < len; i++) mLastBits.push_back(mBits[i]);
        end else begin
          mDrop = 1;
        end
      end
      mBits.delete();
      mInFrame = 0;
      if (load) begin
        mData = word;
        mOvf  = (len > W);
      end
    end else if (sh && !up) begin
      mInFrame = 1;
      mBits.push_back(bitIn);
      if (mBits.size() > 64) void'(mBits.pop_front());
    end
    if (load) mValid = 1;
    else if (mValid && rdy) mValid = 0;
  endtask

  // Drive one cycle of inputs, advance the model and compare every output.
  task automatic applyStimulus(input bit rst, input bit sh, input bit up, input bit bitIn,
                               input bit rdy);
    @(negedge clk_tck);
    reset    = rst;
    shift_en = sh;
    update   = up;
    tdi      = bitIn;
    ready    = rdy;
    @(posedge clk_tck);
    modelEdge(rst, sh, up, bitIn, rdy);
    #1;
    checkOutput("valid", W'(valid), W'(mValid));
    checkOutput("data_out", data_out, mData);
    checkOutput("overflow", W'(overflow), W'(mOvf));
    checkOutput("short_frame", W'(short_frame), W'(mShort));
    checkOutput("dropped", W'(dropped), W'(mDrop));
  endtask

  // Shift n bits of val MSB first with a fixed ready level.
  task automatic shiftBits(input logic [63:0] val, input int n, input bit rdy);
    logic [63:0] v;
    v = val;
    for (int i = n - 1; i >= 0; i--) applyStimulus(0, 1, 0, v[i], rdy);
  endtask

  // Stand-in for the TDO transmitter: serialize data_out MSB first and compare
  // against the tdi bits of the frame that produced it.
  task automatic loopbackCheck();
    logic [W-1:0] word;
    word = data_out;
    if (mLastBits.size() != W) return;
    for (int i = 0; i < W; i++)
      checkOutput("loopback", W'(word[W-1-i]), W'(mLastBits[i]));
  endtask

  initial begin
    reset = 1; shift_en = 0; update = 0; tdi = 0; ready = 0;
    mInFrame = 0; mValid = 0; mData = '0; mOvf = 0; mShort = 0; mDrop = 0;

    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset_data", data_out, 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    // Update with no frame open produces nothing.
    applyStimulus(0, 0, 1, 0, 0);

    // Exact frame, ready held high.
    shiftBits(64'hDEADBEEF, 32, 1);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("exact_data", data_out, 32'hDEADBEEF);
    checkOutput("exact_valid", W'(valid), 32'd1);
    loopbackCheck();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("exact_valid_fall", W'(valid), 32'd0);

    // Short frame then a good frame.
    shiftBits(64'h1234567, 31, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("short_pulse", W'(short_frame), 32'd1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("short_pulse_end", W'(short_frame), 32'd0);
    shiftBits(64'h89ABCDEF, 32, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("after_short", data_out, 32'h89ABCDEF);
    applyStimulus(0, 0, 0, 0, 1);

    // Overflow: 36 bits, last 32 form 0x12345678.
    shiftBits(64'hA_1234_5678, 36, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("ovf_data", data_out, 32'h12345678);
    checkOutput("ovf_flag", W'(overflow), 32'd1);
    applyStimulus(0, 0, 0, 0, 1);

    // Backpressure: second frame dropped, then accepted on a ready edge.
    shiftBits(64'hAAAA5555, 32, 0);
    applyStimulus(0, 0, 1, 0, 0);
    shiftBits(64'h0F0F0F0F, 32, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("bp_dropped", W'(dropped), 32'd1);
    checkOutput("bp_hold", data_out, 32'hAAAA5555);
    shiftBits(64'h0F0F0F0F, 32, 0);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("bp_replace", data_out, 32'h0F0F0F0F);
    checkOutput("bp_valid_held", W'(valid), 32'd1);
    applyStimulus(0, 0, 0, 0, 1);

    // Reset mid-frame with a word pending, then a clean frame.
    shiftBits(64'h11112222, 32, 0);
    applyStimulus(0, 0, 1, 0, 0);
    shiftBits(64'hBEEF, 16, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("mid_reset_valid", W'(valid), 32'd0);
    applyStimulus(0, 0, 0, 0, 0);
    shiftBits(64'hCAFEF00D, 32, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("post_reset_data", data_out, 32'hCAFEF00D);
    loopbackCheck();
    applyStimulus(0, 0, 0, 0, 1);

    // Random frames with pauses, random lengths and random ready.
    for (int f = 0; f < 60; f++) begin
      int len;
      int shifted;
      len = ($urandom_range(0, 1) == 1) ? W : int'($urandom_range(W - 4, W + 4));
      shifted = 0;
      while (shifted < len) begin
        if ($urandom_range(0, 4) == 0) begin
          applyStimulus(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1));
        end else begin
          applyStimulus(0, 1, 0, $urandom_range(0, 1), $urandom_range(0, 1));
          shifted++;
        end
      end
      if ($urandom_range(0, 29) == 0) begin
        applyStimulus(1, 0, 0, 0, 0);
      end else begin
        applyStimulus(0, $urandom_range(0, 1), 1, $urandom_range(0, 1), $urandom_range(0, 1));
        if (len == W && mValid) loopbackCheck();
      end
      for (int g = $urandom_range(0, 2); g > 0; g--)
        applyStimulus(0, 0, 0, 0, $urandom_range(0, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
